// File: rtl/sync_memory.sv
// sync_memory: single-port word memory with byte-lane writes and a fixed-latency
// response pipeline. After reset, and on a clear pulse, a sweep zeroes every
// word one per cycle before requests are accepted again.
module sync_memory #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  input  logic                clear,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_busy
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int OFS_W   = $clog2(STRB_W);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int TOP_LSB = OFS_W + IDX_W;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  sweep_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              in_range;
  logic [IDX_W-1:0]  req_idx;

  // Response pipeline; stage 0 is loaded on the accept edge.
  logic              pipe_valid [READ_LAT];
  logic [DATA_W-1:0] pipe_rdata [READ_LAT];
  logic              pipe_err   [READ_LAT];

  assign accept   = req_valid && req_ready;
  // Byte-offset bits are dropped; anything above the word index is out of range.
  assign req_idx  = req_addr[TOP_LSB-1:OFS_W];
  assign in_range = ((req_addr >> TOP_LSB) == '0);

  // Sweep/ready state machine; ready and busy flags are registered with the state.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      sweep_idx <= '0;
      req_ready <= 1'b0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          if (sweep_idx == IDX_W'(DEPTH - 1)) begin
            state     <= ST_READY;
            sweep_idx <= '0;
            req_ready <= 1'b1;
            init_busy <= 1'b0;
          end else begin
            sweep_idx <= sweep_idx + IDX_W'(1);
          end
        end
        ST_READY: begin
          // A request accepted on this same edge still completes normally.
          if (clear) begin
            state     <= ST_INIT;
            sweep_idx <= '0;
            req_ready <= 1'b0;
            init_busy <= 1'b1;
          end
        end
        default: begin
          state     <= ST_INIT;
          sweep_idx <= '0;
          req_ready <= 1'b0;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

  // Storage writes: the zeroing sweep during INIT, byte-masked requests in READY.
  // NOTE: the array is deliberately left out of reset; the sweep initialises it,
  // which keeps it mappable onto RAM macros.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[sweep_idx] <= '0;
    end else if (accept && req_write && in_range) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (req_wstrb[i]) begin
          mem[req_idx][i*8 +: 8] <= req_wdata[i*8 +: 8];
        end
      end
    end
  end

  // Response pipeline: capture the pre-edge word on accept, then shift toward the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_rdata[i] <= '0;
        pipe_err[i]   <= 1'b0;
      end
    end else begin
      pipe_valid[0] <= accept;
      pipe_err[0]   <= accept && !in_range;
      pipe_rdata[0] <= (accept && !req_write && in_range) ? mem[req_idx] : '0;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_rdata[i] <= pipe_rdata[i-1];
        pipe_err[i]   <= pipe_err[i-1];
      end
    end
  end

  assign rsp_valid = pipe_valid[READ_LAT-1];
  assign rsp_rdata = pipe_rdata[READ_LAT-1];
  assign rsp_err   = pipe_err[READ_LAT-1];

endmodule

// File: tb/tb_sync_memory.sv
// tb_sync_memory: scoreboard bench. The driver pushes the hand-computed response
// of each accepted request; a negedge monitor pops and compares. A second
// instance with READ_LAT=4 covers reset during an in-flight read.
module tb_sync_memory;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 256;
  localparam int LAT    = 2;
  localparam int LAT4   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: at any negedge it equals the number of rising edges so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance under main test (READ_LAT=2)
  logic              rst_n, req_valid, req_ready, req_write, clear;
  logic              rsp_valid, rsp_err, init_busy;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata, rsp_rdata;
  logic [1:0]        req_wstrb;

  // Instance for the reset-while-in-flight test (READ_LAT=4)
  logic              rst4_n, req_valid4, req_ready4, req_write4, clear4;
  logic              rsp_valid4, rsp_err4, init_busy4;
  logic [ADDR_W-1:0] req_addr4;
  logic [DATA_W-1:0] req_wdata4, rsp_rdata4;
  logic [1:0]        req_wstrb4;

  sync_memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .clear(clear), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .init_busy(init_busy)
  );

  sync_memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(LAT4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_write(req_write4), .req_addr(req_addr4), .req_wdata(req_wdata4),
    .req_wstrb(req_wstrb4), .clear(clear4), .rsp_valid(rsp_valid4),
    .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4), .init_busy(init_busy4)
  );

  typedef struct {
    string       name;
    logic [15:0] rdata;
    logic        err;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_pass  = 0;
  int n_total = 0;
  int bad4    = 0;
  bit watch4  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Drive one request on the next edge (caller sits just after an edge).
  task automatic issue(input string name, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [1:0] strb, input logic clr,
                       input logic [15:0] exp_rdata, input logic exp_err);
    exp_t e;
    check({name, " ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
    clear     = clr;
    e.name  = name;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    // Accept on edge cyc+1; output stage updates on edge cyc+LAT.
    e.at    = cyc + LAT;
    if (req_ready) sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    clear     = 1'b0;
  endtask

  // Count rising edges until init_busy drops; optional clear pulse on edge clr_at+1.
  task automatic wait_ready(input bit sel4, input int clr_at, output int n);
    n = 0;
    while (n < 2000) begin
      if (!sel4) clear = (n == clr_at);
      @(posedge clk);
      n++;
      #1;
      clear = 1'b0;
      if (!(sel4 ? init_busy4 : init_busy)) break;
    end
  endtask

  // Scoreboard monitor for the main instance.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected rsp", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, " rdata"}, rsp_rdata, mon_e.rdata);
        check({mon_e.name, " err"}, rsp_err, mon_e.err);
        check({mon_e.name, " latency"}, cyc, mon_e.at);
      end
    end else if (rsp_rdata != '0 || rsp_err) begin
      check("idle rsp zero", {rsp_rdata, rsp_err}, 0);
    end
  end

  always @(negedge clk) if (watch4 && rsp_valid4) bad4++;

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0; clear = 1'b0;
    rst4_n = 1'b0; req_valid4 = 1'b0; req_write4 = 1'b0; req_addr4 = '0;
    req_wdata4 = '0; req_wstrb4 = '0; clear4 = 1'b0;

    #12;
    check("reset rsp_valid", rsp_valid, 0);
    check("reset req_ready", req_ready, 0);
    check("reset init_busy", init_busy, 1);
    check("reset rsp_rdata", rsp_rdata, 0);

    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(1'b0, -1, n);
    check("init sweep cycles", n, 256);
    check("ready after sweep", req_ready, 1);

    // Fresh memory reads zero; byte offset ignored.
    issue("rd 0000", 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0);
    issue("rd 01FE", 0, 16'h01FE, 16'h0000, 2'b00, 0, 16'h0000, 0);
    issue("rd 0081", 0, 16'h0081, 16'h0000, 2'b00, 0, 16'h0000, 0);
    // Full write then read on the next cycle.
    issue("wr ABCD", 1, 16'h0010, 16'hABCD, 2'b11, 0, 16'h0000, 0);
    issue("rd ABCD", 0, 16'h0010, 16'h0000, 2'b00, 0, 16'hABCD, 0);
    // Low-lane write, read through the aliasing odd address.
    issue("wr lo34", 1, 16'h0010, 16'h1234, 2'b01, 0, 16'h0000, 0);
    issue("rd AB34", 0, 16'h0011, 16'h0000, 2'b00, 0, 16'hAB34, 0);
    // High-lane write to the last word.
    issue("wr hi5A", 1, 16'h01FE, 16'h5A5A, 2'b10, 0, 16'h0000, 0);
    issue("rd 5A00", 0, 16'h01FF, 16'h0000, 2'b00, 0, 16'h5A00, 0);
    // Out-of-range requests.
    issue("rd 0200", 0, 16'h0200, 16'h0000, 2'b00, 0, 16'h0000, 1);
    issue("wr 0200", 1, 16'h0200, 16'hFFFF, 2'b11, 0, 16'h0000, 1);
    issue("wr 8000", 1, 16'h8000, 16'hFFFF, 2'b11, 0, 16'h0000, 1);
    issue("rd w0 ok", 0, 16'h0000, 16'h0000, 2'b00, 0, 16'h0000, 0);
    // Four back-to-back reads, clear on the edge of the last one.
    issue("b2b 0", 0, 16'h0010, 16'h0000, 2'b00, 0, 16'hAB34, 0);
    issue("b2b 1", 0, 16'h01FE, 16'h0000, 2'b00, 0, 16'h5A00, 0);
    issue("b2b 2", 0, 16'h0200, 16'h0000, 2'b00, 0, 16'h0000, 1);
    issue("b2b 3", 0, 16'h0011, 16'h0000, 2'b00, 1, 16'hAB34, 0);
    check("busy after clear", init_busy, 1);
    check("not ready after clear", req_ready, 0);
    // A clear pulse mid-sweep must not restart it.
    wait_ready(1'b0, 100, n);
    check("clear sweep cycles", n, 256);
    issue("clr rd 0010", 0, 16'h0010, 16'h0000, 2'b00, 0, 16'h0000, 0);
    issue("clr rd 01FE", 0, 16'h01FE, 16'h0000, 2'b00, 0, 16'h0000, 0);
    repeat (6) @(posedge clk);
    #1;
    check("scoreboard drained", sb.size(), 0);

    // READ_LAT=4 instance: reset one cycle after accepting a read.
    @(negedge clk);
    rst4_n = 1'b1;
    wait_ready(1'b1, -1, n);
    check("dut4 sweep cycles", n, 256);
    req_valid4 = 1'b1; req_write4 = 1'b1; req_addr4 = 16'h0002;
    req_wdata4 = 16'hBEEF; req_wstrb4 = 2'b11;
    @(posedge clk); #1;
    req_valid4 = 1'b0; req_write4 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    req_valid4 = 1'b1;
    @(posedge clk); #1;
    req_valid4 = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk); n++; #1;
      if (rsp_valid4) break;
    end
    check("dut4 rd latency", n, LAT4 - 1);
    check("dut4 rd BEEF", rsp_rdata4, 16'hBEEF);
    @(posedge clk); #1;
    // Accept a read, then reset on the following cycle.
    req_valid4 = 1'b1;
    @(posedge clk); #1;
    req_valid4 = 1'b0;
    watch4 = 1'b1;
    @(posedge clk); #1;
    rst4_n = 1'b0;
    #1;
    check("dut4 async ready", req_ready4, 0);
    check("dut4 async busy", init_busy4, 1);
    check("dut4 async rsp_valid", rsp_valid4, 0);
    @(posedge clk); #1;
    rst4_n = 1'b1;
    wait_ready(1'b1, -1, n);
    repeat (3) @(posedge clk);
    #1;
    watch4 = 1'b0;
    check("dut4 resweep cycles", n, 256);
    check("dut4 stale rsp count", bad4, 0);
    req_valid4 = 1'b1;
    @(posedge clk); #1;
    req_valid4 = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk); n++; #1;
      if (rsp_valid4) break;
    end
    check("dut4 post-reset latency", n, LAT4 - 1);
    check("dut4 post-reset rdata", rsp_rdata4, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
